permuter_net_pipe: RTL and testbench

Pipelined 4x4 permutation network for the bufferless (BLESS) router datapath, built from two ranks of priority-arbitrated 2x2 swap stages with a pipeline register after each rank. Every valid input flit leaves on exactly one output port; contention is resolved by priority, and losers are deflected rather than buffered. The block sits between the router input latches and the output port registers, replacing fixed-swap permuting with age/golden-priority steering toward each flit's preferred port.

---
 rtl/permuter_net_pipe.sv | 171 +++++++++++++++++
 tb/tb_permuter_net_pipe.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/permuter_net_pipe.sv
// Two-rank pipelined 4x4 deflection permuter for the BLESS router datapath.
// Define GOLDEN_PRIORITY_EN to add golden-packet priority, the epoch counter and golden_id register.
module permuter_net_pipe #(
  parameter int FLIT_WIDTH   = 32,
  parameter int AGE_WIDTH    = 8,
  parameter int ID_WIDTH     = 4,
  parameter int GOLDEN_EPOCH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              in_valid,
  input  logic [4*FLIT_WIDTH-1:0] in_flit,
  input  logic [4*AGE_WIDTH-1:0]  in_age,
  input  logic [4*ID_WIDTH-1:0]   in_pkt_id,
  input  logic [7:0]              in_pref,
  output logic [3:0]              out_valid,
  output logic [4*FLIT_WIDTH-1:0] out_flit,
  output logic [4*AGE_WIDTH-1:0]  out_age,
  output logic [3:0]              out_defl,
  output logic [ID_WIDTH-1:0]     golden_id
);

  typedef struct packed {
    logic                  vld;
`ifdef GOLDEN_PRIORITY_EN
    logic                  gold;
`endif
    logic [1:0]            pref;
    logic [AGE_WIDTH-1:0]  age;
    logic [FLIT_WIDTH-1:0] flit;
  } lane_t;

  // Arbitration order: valid, golden (when enabled), older age, then top input.
  function automatic logic top_wins(lane_t t, lane_t b);
    if (t.vld != b.vld) return t.vld;
`ifdef GOLDEN_PRIORITY_EN
    if (t.gold != b.gold) return t.gold;
`endif
    if (t.age != b.age) return (t.age > b.age);
    return 1'b1;
  endfunction

  // Swap when the winner must move: top winner steering low, or bottom winner steering high.
  function automatic logic swap_sel(lane_t t, lane_t b, logic use_bit0);
    logic tw;
    logic steer;
    tw    = top_wins(t, b);
    steer = tw ? (use_bit0 ? t.pref[0] : t.pref[1])
               : (use_bit0 ? b.pref[0] : b.pref[1]);
    if (!t.vld && !b.vld) return 1'b0;
    return tw ? steer : ~steer;
  endfunction

  function automatic logic [AGE_WIDTH-1:0] sat_inc(logic [AGE_WIDTH-1:0] a);
    return (&a) ? a : a + AGE_WIDTH'(1);
  endfunction

  lane_t [3:0] in_lane_p0;
  lane_t [3:0] lane_p1_d, lane_p1_q;
  lane_t [3:0] fin_p1;
  logic        sw0_p0, sw1_p0, sw2_p1, sw3_p1;

  logic [3:0]              out_valid_d, out_valid_q;
  logic [4*FLIT_WIDTH-1:0] out_flit_d,  out_flit_q;
  logic [4*AGE_WIDTH-1:0]  out_age_d,   out_age_q;
  logic [3:0]              out_defl_d,  out_defl_q;

`ifdef GOLDEN_PRIORITY_EN
  localparam int CNT_W = (GOLDEN_EPOCH > 2) ? $clog2(GOLDEN_EPOCH) : 1;

  logic [CNT_W-1:0]    epoch_d, epoch_q;
  logic [ID_WIDTH-1:0] golden_id_d, golden_id_q;
  logic                unused_fin_gold;

  always_comb begin
    epoch_d     = epoch_q + CNT_W'(1);
    golden_id_d = golden_id_q;
    if (epoch_q == CNT_W'(GOLDEN_EPOCH - 1)) begin
      epoch_d     = '0;
      golden_id_d = golden_id_q + ID_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      epoch_q     <= '0;
      golden_id_q <= '0;
    end else begin
      epoch_q     <= epoch_d;
      golden_id_q <= golden_id_d;
    end
  end

  assign golden_id       = golden_id_q;
  assign unused_fin_gold = ^{fin_p1[0].gold, fin_p1[1].gold, fin_p1[2].gold, fin_p1[3].gold};
`else
  logic unused_pkt_id;

  assign golden_id     = '0;
  assign unused_pkt_id = ^in_pkt_id;
`endif

  // Stage p0: unpack ports, tag golden flits, rank-1 steering on the output-half bit
  always_comb begin
    in_lane_p0 = '0;
    for (int p = 0; p < 4; p++) begin
      in_lane_p0[p].vld  = in_valid[p];
      in_lane_p0[p].pref = in_pref[2*p +: 2];
      in_lane_p0[p].age  = in_age[p*AGE_WIDTH +: AGE_WIDTH];
      in_lane_p0[p].flit = in_flit[p*FLIT_WIDTH +: FLIT_WIDTH];
`ifdef GOLDEN_PRIORITY_EN
      in_lane_p0[p].gold = (in_pkt_id[p*ID_WIDTH +: ID_WIDTH] == golden_id_q);
`endif
    end
  end

  always_comb begin
    sw0_p0       = swap_sel(in_lane_p0[0], in_lane_p0[1], 1'b0);
    sw1_p0       = swap_sel(in_lane_p0[2], in_lane_p0[3], 1'b0);
    lane_p1_d[0] = sw0_p0 ? in_lane_p0[1] : in_lane_p0[0];
    lane_p1_d[1] = sw0_p0 ? in_lane_p0[0] : in_lane_p0[1];
    lane_p1_d[2] = sw1_p0 ? in_lane_p0[3] : in_lane_p0[2];
    lane_p1_d[3] = sw1_p0 ? in_lane_p0[2] : in_lane_p0[3];
  end

  // Stage p1: rank-2 steering on the low pref bit using the registered golden flag
  always_comb begin
    sw2_p1    = swap_sel(lane_p1_q[0], lane_p1_q[2], 1'b1);
    sw3_p1    = swap_sel(lane_p1_q[1], lane_p1_q[3], 1'b1);
    fin_p1[0] = sw2_p1 ? lane_p1_q[2] : lane_p1_q[0];
    fin_p1[1] = sw2_p1 ? lane_p1_q[0] : lane_p1_q[2];
    fin_p1[2] = sw3_p1 ? lane_p1_q[3] : lane_p1_q[1];
    fin_p1[3] = sw3_p1 ? lane_p1_q[1] : lane_p1_q[3];
  end

  always_comb begin
    out_valid_d = '0;
    out_flit_d  = '0;
    out_age_d   = '0;
    out_defl_d  = '0;
    for (int p = 0; p < 4; p++) begin
      out_valid_d[p]                          = fin_p1[p].vld;
      out_flit_d[p*FLIT_WIDTH +: FLIT_WIDTH]  = fin_p1[p].flit;
      out_age_d[p*AGE_WIDTH +: AGE_WIDTH]     = sat_inc(fin_p1[p].age);
      out_defl_d[p]                           = fin_p1[p].vld & (fin_p1[p].pref != 2'(p));
    end
  end

  // Stage p2: output port registers
  always_ff @(posedge clk) begin
    if (reset) begin
      lane_p1_q   <= '0;
      out_valid_q <= '0;
      out_flit_q  <= '0;
      out_age_q   <= '0;
      out_defl_q  <= '0;
    end else begin
      lane_p1_q   <= lane_p1_d;
      out_valid_q <= out_valid_d;
      out_flit_q  <= out_flit_d;
      out_age_q   <= out_age_d;
      out_defl_q  <= out_defl_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_flit  = out_flit_q;
  assign out_age   = out_age_q;
  assign out_defl  = out_defl_q;

endmodule

// File: tb/tb_permuter_net_pipe.sv
// Scoreboard bench for permuter_net_pipe: a winner/loser network model predicts every output beat.
module tb_permuter_net_pipe;
  localparam int FW    = 32;
  localparam int AW    = 8;
  localparam int IW    = 4;
  localparam int EPOCH = 64;
`ifdef GOLDEN_PRIORITY_EN
  localparam bit GOLD_ON = 1'b1;
`else
  localparam bit GOLD_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    in_valid;
  logic [4*FW-1:0] in_flit;
  logic [4*AW-1:0] in_age;
  logic [4*IW-1:0] in_pkt_id;
  logic [7:0]    in_pref;
  logic [3:0]    out_valid;
  logic [4*FW-1:0] out_flit;
  logic [4*AW-1:0] out_age;
  logic [3:0]    out_defl;
  logic [IW-1:0] golden_id;

  always #5 clk = ~clk;

  permuter_net_pipe #(.FLIT_WIDTH(FW), .AGE_WIDTH(AW), .ID_WIDTH(IW), .GOLDEN_EPOCH(EPOCH)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_flit(in_flit), .in_age(in_age),
    .in_pkt_id(in_pkt_id), .in_pref(in_pref), .out_valid(out_valid), .out_flit(out_flit),
    .out_age(out_age), .out_defl(out_defl), .golden_id(golden_id)
  );

  typedef struct {
    logic          v;
    logic [FW-1:0] f;
    logic [AW-1:0] age;
    logic [1:0]    pref;
    logic [IW-1:0] id;
    logic          gold;
  } fl_t;

  typedef struct {
    logic [3:0]    v;
    logic [4*FW-1:0] f;
    logic [4*AW-1:0] age;
    logic [3:0]    defl;
  } exp_t;

  exp_t          sb[$];
  fl_t           stim[4];
  int            errors = 0;
  int            checks = 0;
  int            gcnt   = 0;
  logic [IW-1:0] gid    = '0;
  logic [FW-1:0] fv[4];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit top_beats(fl_t t, fl_t b);
    if (t.v && !b.v) return 1'b1;
    if (!t.v && b.v) return 1'b0;
    if (GOLD_ON && t.gold && !b.gold) return 1'b1;
    if (GOLD_ON && !t.gold && b.gold) return 1'b0;
    if (t.age > b.age) return 1'b1;
    if (b.age > t.age) return 1'b0;
    return 1'b1;
  endfunction

  task automatic swap2(input fl_t t, input fl_t b, input int bitsel, output fl_t o_top, output fl_t o_bot);
    fl_t w;
    fl_t l;
    w = top_beats(t, b) ? t : b;
    l = top_beats(t, b) ? b : t;
    if (!t.v && !b.v) begin
      o_top = t;
      o_bot = b;
    end else if (w.pref[bitsel] == 1'b0) begin
      o_top = w;
      o_bot = l;
    end else begin
      o_top = l;
      o_bot = w;
    end
  endtask

  task automatic model(output exp_t e);
    fl_t l[4];
    fl_t o[4];
    swap2(stim[0], stim[1], 1, l[0], l[1]);
    swap2(stim[2], stim[3], 1, l[2], l[3]);
    swap2(l[0], l[2], 0, o[0], o[1]);
    swap2(l[1], l[3], 0, o[2], o[3]);
    for (int p = 0; p < 4; p++) begin
      e.v[p]              = o[p].v;
      e.f[p*FW +: FW]     = o[p].f;
      e.age[p*AW +: AW]   = (o[p].age == 8'hFF) ? 8'hFF : o[p].age + 8'd1;
      e.defl[p]           = o[p].v && (o[p].pref != 2'(p));
    end
  endtask

  task automatic check_out();
    exp_t e;
    logic [4*FW-1:0] fm;
    logic [4*AW-1:0] am;
    while (sb.size() > 1) begin
      e  = sb.pop_front();
      fm = '0;
      am = '0;
      for (int p = 0; p < 4; p++)
        if (e.v[p]) begin
          fm[p*FW +: FW] = '1;
          am[p*AW +: AW] = '1;
        end
      chk("sb_valid", 128'(out_valid), 128'(e.v));
      chk("sb_flit",  out_flit & fm, e.f & fm);
      chk("sb_age",   128'(out_age & am), 128'(e.age & am));
      chk("sb_defl",  128'(out_defl), 128'(e.defl));
    end
  endtask

  task automatic set_fl(input int p, input logic v, input logic [FW-1:0] f, input logic [AW-1:0] age,
                        input logic [1:0] pref, input logic [IW-1:0] id);
    stim[p].v    = v;
    stim[p].f    = f;
    stim[p].age  = age;
    stim[p].pref = pref;
    stim[p].id   = id;
  endtask

  task automatic clear_stim();
    for (int p = 0; p < 4; p++) set_fl(p, 1'b0, 32'h0, 8'h0, 2'd0, 4'hA);
  endtask

  task automatic rand_stim();
    for (int p = 0; p < 4; p++)
      set_fl(p, 1'($urandom), $urandom, 8'($urandom), 2'($urandom), 4'($urandom));
  endtask

  task automatic step();
    exp_t e;
    for (int p = 0; p < 4; p++) begin
      stim[p].gold            = (stim[p].id == gid);
      in_valid[p]             = stim[p].v;
      in_flit[p*FW +: FW]     = stim[p].f;
      in_age[p*AW +: AW]      = stim[p].age;
      in_pref[2*p +: 2]       = stim[p].pref;
      in_pkt_id[p*IW +: IW]   = stim[p].id;
    end
    model(e);
    sb.push_back(e);
    @(posedge clk);
    if (gcnt == EPOCH - 1) begin
      gcnt = 0;
      gid  = gid + 4'd1;
    end else begin
      gcnt++;
    end
    #1;
    check_out();
    chk("golden_track", 128'(golden_id), GOLD_ON ? 128'(gid) : 128'(0));
  endtask

  task automatic reset_cycles(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_valid  = 4'($urandom);
      in_flit   = {$urandom, $urandom, $urandom, $urandom};
      in_age    = $urandom;
      in_pkt_id = 16'($urandom);
      in_pref   = 8'($urandom);
      @(posedge clk);
      #1;
      chk("rst_valid", 128'(out_valid), 128'(0));
      chk("rst_flit",  out_flit, 128'(0));
      chk("rst_age",   128'(out_age), 128'(0));
      chk("rst_defl",  128'(out_defl), 128'(0));
      chk("rst_golden", 128'(golden_id), 128'(0));
    end
    sb.delete();
    gcnt  = 0;
    gid   = '0;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int p = 0; p < 4; p++) fv[p] = 32'hC0DE_0000 + 32'(p * 32'h1111);
    reset = 1'b1;
    in_valid = '0; in_flit = '0; in_age = '0; in_pkt_id = '0; in_pref = '0;
    reset_cycles(3);

    // Truly conflict-free pattern for this topology; first result needs two edges.
    set_fl(0, 1, fv[0], 8'd5, 2'd0, 4'hA);
    set_fl(1, 1, fv[1], 8'd5, 2'd2, 4'hA);
    set_fl(2, 1, fv[2], 8'd5, 2'd1, 4'hA);
    set_fl(3, 1, fv[3], 8'd5, 2'd3, 4'hA);
    step();
    chk("first_edge_idle", 128'(out_valid), 128'(0));
    clear_stim();
    step();
    chk("cf_valid", 128'(out_valid), 128'hF);
    chk("cf_flit",  out_flit, {fv[3], fv[1], fv[2], fv[0]});
    chk("cf_age",   128'(out_age), 128'h06060606);
    chk("cf_defl",  128'(out_defl), 128'(0));

    // Identity preference {3,2,1,0}: the half-conflicts in S1/S2 deflect ports 1 and 3.
    for (int p = 0; p < 4; p++) set_fl(p, 1, fv[p], 8'd5, 2'(p), 4'hA);
    step();
    clear_stim();
    step();
    chk("id_flit", out_flit, {fv[1], fv[2], fv[3], fv[0]});
    chk("id_defl", 128'(out_defl), 128'b1010);

    // Full contention on port 0, oldest is port 3.
    set_fl(0, 1, fv[0], 8'd10, 2'd0, 4'hA);
    set_fl(1, 1, fv[1], 8'd20, 2'd0, 4'hA);
    set_fl(2, 1, fv[2], 8'd30, 2'd0, 4'hA);
    set_fl(3, 1, fv[3], 8'd40, 2'd0, 4'hA);
    step();
    clear_stim();
    step();
    chk("fc_valid", 128'(out_valid), 128'hF);
    chk("fc_flit",  out_flit, {fv[0], fv[2], fv[1], fv[3]});
    chk("fc_age",   128'(out_age), {96'h0, 8'd11, 8'd31, 8'd21, 8'd41});
    chk("fc_defl",  128'(out_defl), 128'b1110);

    // Age saturation, then a 7/7 tie in S0.
    clear_stim();
    set_fl(0, 1, fv[0], 8'd255, 2'd0, 4'hA);
    step();
    clear_stim();
    set_fl(0, 1, fv[0], 8'd7, 2'd0, 4'hA);
    set_fl(1, 1, fv[1], 8'd7, 2'd0, 4'hA);
    step();
    chk("sat_age", 128'(out_age[7:0]), 128'd255);
    clear_stim();
    step();
    chk("tie_valid", 128'(out_valid), 128'b0101);
    chk("tie_out0",  128'(out_flit[31:0]), 128'(fv[0]));
    chk("tie_out2",  128'(out_flit[95:64]), 128'(fv[1]));
    chk("tie_defl",  128'(out_defl), 128'b0100);

    // Sparse: lone flit on input 2 wants port 1.
    set_fl(2, 1, fv[2], 8'd3, 2'd1, 4'hA);
    step();
    clear_stim();
    step();
    chk("sp_valid", 128'(out_valid), 128'b0010);
    chk("sp_flit",  128'(out_flit[63:32]), 128'(fv[2]));
    chk("sp_defl",  128'(out_defl), 128'(0));

    // Back-to-back random traffic.
    for (int i = 0; i < 24; i++) begin
      rand_stim();
      step();
    end

    // Reset mid-stream discards in-flight flits.
    for (int p = 0; p < 4; p++) set_fl(p, 1, fv[p], 8'd1, 2'(p), 4'hA);
    step();
    reset_cycles(1);
    for (int p = 0; p < 4; p++) set_fl(p, 1, fv[p], 8'd1, 2'd3, 4'hA);
    step();
    chk("post_rst_idle", 128'(out_valid), 128'(0));
    clear_stim();
    step();
    chk("post_rst_valid", 128'(out_valid), 128'hF);

    // Golden epoch: 63 cycles, then the wrap cycle judged against the old id.
    reset_cycles(2);
    for (int i = 0; i < EPOCH - 1; i++) begin
      rand_stim();
      step();
    end
    chk("pre_wrap_golden", 128'(golden_id), 128'(0));
    clear_stim();
    set_fl(0, 1, fv[0], 8'd200, 2'd0, 4'h1);
    set_fl(1, 1, fv[1], 8'd0,   2'd0, 4'h0);
    step();
    chk("post_wrap_golden", 128'(golden_id), GOLD_ON ? 128'd1 : 128'd0);
    clear_stim();
    set_fl(0, 1, fv[0], 8'd200, 2'd0, 4'h2);
    set_fl(1, 1, fv[1], 8'd0,   2'd0, 4'h1);
    step();
    chk("wrap_out0", 128'(out_flit[31:0]), GOLD_ON ? 128'(fv[1]) : 128'(fv[0]));
    clear_stim();
    step();
    chk("gold_out0", 128'(out_flit[31:0]), GOLD_ON ? 128'(fv[1]) : 128'(fv[0]));
    chk("gold_defl", 128'(out_defl), 128'b0100);

    for (int i = 0; i < 8; i++) begin
      rand_stim();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
